instr_byte_loader: RTL and testbench
====================================

# instr_byte_loader

Byte-serial instruction receiver that sits between the CPU's 8-bit `instr_i` load port and the 32-bit instruction memory write port. It receives the bench/host byte stream, which waits for a start byte and then sends each instruction as four bytes, MSB first. It assembles those bytes into 32-bit words and issues one write per word to consecutive instruction-memory addresses. Loading stops on an all-ones terminator word or when memory is full.

## Interface
- `DEPTH`, 64: instruction memory depth in words.
- `ADDR_W`, 6: width of the word address; equals log2(DEPTH).
- `START_BYTE`, 8'hFE: byte that opens a load session.
- `END_WORD`, 32'hFFFF_FFFF: assembled word that terminates a load. This word is never written.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_i`  in  8  incoming byte, sampled every rising edge.
- `wr_en_o`  out  1  one-cycle instruction-memory write strobe.
- `wr_addr_o`  out  ADDR_W  word address for the write.
- `wr_data_o`  out  32  assembled instruction for the write.
- `busy_o`  out  1  high while in state LOAD.
- `done_o`  out  1  high while in state DONE; sticky until reset.
- `word_count_o`  out  ADDR_W+1  number of words written (0..DEPTH).

## Operation
- States:
  - IDLE: reset state.
  - LOAD: collecting words.
  - DONE: terminal state.
- IDLE:
  - Every byte except START_BYTE is ignored.
  - On `instr_i == START_BYTE`, go to LOAD. Byte phase = 0, write pointer = 0.
  - The start byte itself is not data.
- LOAD:
  - Each cycle, the sampled byte is shifted into the assembly register: phase 0 → [31:24], phase 1 → [23:16], phase 2 → [15:8], phase 3 → [7:0].
  - Phase counts 0..3 and wraps to 0.
  - Bytes are data regardless of value. 8'hFE and 8'hFF inside LOAD are not markers.
- Word completion, when the phase-3 byte is sampled:
  - Assembled word == END_WORD: no write; go to DONE.
  - Otherwise: write {bytes} to address = write pointer; pointer += 1; word_count += 1.
  - If that write was to address DEPTH-1, go to DONE after issuing it.
- DONE:
  - All input ignored; a later START_BYTE does not restart loading.
  - `wr_en_o` stays 0. Only `reset` leaves DONE.
- Width rules:
  - Write pointer is ADDR_W bits and never wraps; the transition to DONE prevents it.
  - word_count saturates at DEPTH by construction.
- Reset is synchronous and takes priority over every other event, including mid-word and in the cycle a write would fire.
  - Reset values: state = IDLE, phase = 0, pointer = 0, assembly register = 0.
  - Output reset values: `wr_en_o` = 0, `wr_addr_o` = 0, `wr_data_o` = 0, `busy_o` = 0, `done_o` = 0, `word_count_o` = 0.
  - A partially assembled word is discarded and never written.

## Timing
- All outputs are registered.
- Start to load: START_BYTE sampled at edge N → `busy_o` = 1 after edge N. The first data byte is sampled at edge N+1.
- Write latency: the phase-3 byte is sampled at edge K. After edge K, for exactly one cycle:
  - `wr_en_o` = 1;
  - `wr_addr_o` and `wr_data_o` hold the new word;
  - `word_count_o` already holds the incremented count.
- Memory captures the write at edge K+1. `wr_addr_o`/`wr_data_o` hold their last values until the next write.
- Throughput: one write per 4 cycles, with no gaps. The stream has no valid/handshake; every cycle in LOAD consumes a byte.
- Transition to DONE:
  - END_WORD completing at edge K → `busy_o` = 0 and `done_o` = 1 after edge K.
  - A write to DEPTH-1 completing at edge K → `done_o` = 1 after edge K, in the same cycle as that `wr_en_o` pulse.
- Reset asserted at edge R → all outputs at reset values after edge R. A write pending from edge R is suppressed.

## Test plan
- Basic load:
  - Stimulus: reset; FE, 00, 00, 00, 13, FF, FF, FF, FF.
  - Response: one write, addr 0, data 32'h0000_0013. Then `done_o` = 1 and `word_count_o` = 1, with no second write.
- Pre-start bytes:
  - Stimulus: 00, 13, FF, FF, FF, FF, then FE, 12, 34, 56, 78.
  - Response: nothing before FE (`busy_o` = 0, no writes); after FE, one write, addr 0, data 32'h1234_5678.
- In-band marker values:
  - Stimulus: FE; then FF, FF, FF, 00; then FE, 00, 00, 01.
  - Response: writes 32'hFFFF_FF00 at addr 0 and 32'hFE00_0001 at addr 1; `busy_o` stays 1.
- Full memory:
  - Stimulus: FE then 64 words, word i = 32'h0000_0000 + i.
  - Response: 64 writes at addr 0..63. `done_o` rises with the 64th write and `word_count_o` = 64. Further bytes, including FE, produce no writes.
- Reset mid-word:
  - Stimulus: FE, AA, BB, then reset for 1 cycle; then FE, 01, 02, 03, 04.
  - Response: no write of AA/BB; all outputs 0 after the reset edge. Then one write, addr 0, data 32'h0102_0304.
- Reset coincident with the phase-3 byte:
  - Stimulus: reset asserted on the edge that samples the 4th byte.
  - Response: no `wr_en_o` pulse; state IDLE; `word_count_o` = 0.

Source files
------------

// File: rtl/instr_byte_loader_if.sv
// Byte-stream input and instruction-memory write port of the byte loader.
// The master side drives the byte stream; the slave side is the loader.
interface instr_byte_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        instr_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   word_count_o;

  modport master (
    output instr_i,
    input  wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, word_count_o
  );

  modport slave (
    input  instr_i,
    output wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, word_count_o
  );
endinterface

// File: rtl/instr_byte_loader.sv
// Byte-serial instruction loader: waits for a start byte, assembles four
// bytes (MSB first) into a word and writes it to consecutive addresses.
// Stops on an all-ones terminator word or after the last address is written.
module instr_byte_loader #(
  parameter int          DEPTH      = 64,
  parameter int          ADDR_W     = 6,
  parameter logic [7:0]  START_BYTE = 8'hFE,
  parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF
) (
  input logic                clk_i,
  input logic                reset,
  instr_byte_loader_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r, state_nx_s;
  logic [1:0]        phase_r, phase_nx_s;
  logic [ADDR_W-1:0] ptr_r, ptr_nx_s;
  logic [31:0]       asm_r, asm_nx_s;
  logic [31:0]       word_s;
  logic              wr_en_r, wr_en_nx_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_nx_s;
  logic [31:0]       wr_data_r, wr_data_nx_s;
  logic [ADDR_W:0]   count_r, count_nx_s;
  logic              busy_r, done_r;

  // Place the current byte into the lane selected by the byte phase.
  always_comb begin
    word_s = asm_r;
    case (phase_r)
      2'd0:    word_s[31:24] = bus.instr_i;
      2'd1:    word_s[23:16] = bus.instr_i;
      2'd2:    word_s[15:8]  = bus.instr_i;
      default: word_s[7:0]   = bus.instr_i;
    endcase
  end

  // Next-state and next-output logic of the load FSM.
  always_comb begin
    state_nx_s   = state_r;
    phase_nx_s   = phase_r;
    ptr_nx_s     = ptr_r;
    asm_nx_s     = asm_r;
    wr_en_nx_s   = 1'b0;
    wr_addr_nx_s = wr_addr_r;
    wr_data_nx_s = wr_data_r;
    count_nx_s   = count_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.instr_i == START_BYTE) begin
          state_nx_s = ST_LOAD;
          phase_nx_s = 2'd0;
          ptr_nx_s   = {ADDR_W{1'b0}};
          asm_nx_s   = 32'h0000_0000;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Every byte in LOAD is data, marker values included.
        asm_nx_s   = word_s;
        phase_nx_s = phase_r + 2'd1;
        if (phase_r == 2'd3) begin
          if (word_s == END_WORD) begin
            state_nx_s = ST_DONE;
          end else begin
            wr_en_nx_s   = 1'b1;
            wr_addr_nx_s = ptr_r;
            wr_data_nx_s = word_s;
            count_nx_s   = count_r + (ADDR_W + 1)'(1);
            // Last address: finish instead of letting the pointer wrap.
            if (ptr_r == LAST_ADDR) begin
              state_nx_s = ST_DONE;
              ptr_nx_s   = ptr_r;
            end else begin
              ptr_nx_s   = ptr_r + ADDR_W'(1);
            end
          end
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_DONE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      phase_r   <= 2'd0;
      ptr_r     <= {ADDR_W{1'b0}};
      asm_r     <= 32'h0000_0000;
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= 32'h0000_0000;
      count_r   <= {(ADDR_W + 1){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      phase_r   <= phase_nx_s;
      ptr_r     <= ptr_nx_s;
      asm_r     <= asm_nx_s;
      wr_en_r   <= wr_en_nx_s;
      wr_addr_r <= wr_addr_nx_s;
      wr_data_r <= wr_data_nx_s;
      count_r   <= count_nx_s;
      busy_r    <= (state_nx_s == ST_LOAD);
      done_r    <= (state_nx_s == ST_DONE);
    end
  end

  assign bus.wr_en_o      = wr_en_r;
  assign bus.wr_addr_o    = wr_addr_r;
  assign bus.wr_data_o    = wr_data_r;
  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;
  assign bus.word_count_o = count_r;

endmodule

// File: tb/tb_instr_byte_loader.sv
// Directed bench for instr_byte_loader: drives byte vectors and compares
// outputs and the logged write stream against hand-computed values.
module tb_instr_byte_loader;

  logic clk_i = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];

  instr_byte_loader_if #(.ADDR_W(6)) bus ();

  instr_byte_loader #(
    .DEPTH(64), .ADDR_W(6), .START_BYTE(8'hFE), .END_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk_i (clk_i),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Record every write pulse, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (bus.wr_en_o) begin
      log_addr.push_back(bus.wr_addr_o);
      log_data.push_back(bus.wr_data_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte (optionally with reset) for one rising edge, return #1 after it.
  task automatic send(input logic [7:0] b, input logic rst);
    @(negedge clk_i);
    bus.instr_i = b;
    reset = rst;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    send(8'h00, 1'b1);
    chk("rst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
    chk("rst_done",  {31'd0, bus.done_o}, 32'd0);
    chk("rst_count", {25'd0, bus.word_count_o}, 32'd0);
    chk("rst_addr",  {26'd0, bus.wr_addr_o}, 32'd0);
    chk("rst_data",  bus.wr_data_o, 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24], 1'b0);
    send(w[23:16], 1'b0);
    send(w[15:8], 1'b0);
    send(w[7:0], 1'b0);
  endtask

  initial begin
    int base;
    int errs;
    logic [7:0] pre [6];
    bus.instr_i = 8'h00;

    // Basic load with terminator.
    do_reset();
    base = log_addr.size();
    send(8'hFE, 1'b0);
    chk("basic_busy_after_start", {31'd0, bus.busy_o}, 32'd1);
    send_word(32'h0000_0013);
    chk("basic_wr_en",  {31'd0, bus.wr_en_o}, 32'd1);
    chk("basic_addr",   {26'd0, bus.wr_addr_o}, 32'd0);
    chk("basic_data",   bus.wr_data_o, 32'h0000_0013);
    chk("basic_count",  {25'd0, bus.word_count_o}, 32'd1);
    send_word(32'hFFFF_FFFF);
    chk("basic_done",   {31'd0, bus.done_o}, 32'd1);
    chk("basic_busy0",  {31'd0, bus.busy_o}, 32'd0);
    chk("basic_wr_en0", {31'd0, bus.wr_en_o}, 32'd0);
    chk("basic_count2", {25'd0, bus.word_count_o}, 32'd1);
    send(8'h00, 1'b0);
    chk("basic_nwrites", log_addr.size() - base, 32'd1);

    // Bytes before the start byte are ignored.
    do_reset();
    base = log_addr.size();
    pre = '{8'h00, 8'h13, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      send(pre[i], 1'b0);
      if (bus.busy_o !== 1'b0 || bus.wr_en_o !== 1'b0) errs++;
    end
    chk("pre_idle", errs, 32'd0);
    send(8'hFE, 1'b0);
    send_word(32'h1234_5678);
    chk("pre_wr_en", {31'd0, bus.wr_en_o}, 32'd1);
    send(8'h00, 1'b0);
    chk("pre_nwrites", log_addr.size() - base, 32'd1);
    if (log_addr.size() > base) begin
      chk("pre_addr", {26'd0, log_addr[base]}, 32'd0);
      chk("pre_data", log_data[base], 32'h1234_5678);
    end

    // Marker values inside LOAD are plain data.
    do_reset();
    base = log_addr.size();
    send(8'hFE, 1'b0);
    send_word(32'hFFFF_FF00);
    send_word(32'hFE00_0001);
    send(8'h00, 1'b0);
    chk("inband_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("inband_nwrites", log_addr.size() - base, 32'd2);
    if (log_addr.size() >= base + 2) begin
      chk("inband_addr0", {26'd0, log_addr[base]}, 32'd0);
      chk("inband_data0", log_data[base], 32'hFFFF_FF00);
      chk("inband_addr1", {26'd0, log_addr[base+1]}, 32'd1);
      chk("inband_data1", log_data[base+1], 32'hFE00_0001);
    end

    // Fill all 64 words.
    do_reset();
    base = log_addr.size();
    send(8'hFE, 1'b0);
    for (int i = 0; i < 63; i++) send_word(i);
    chk("full_done_before_last", {31'd0, bus.done_o}, 32'd0);
    send_word(32'd63);
    chk("full_wr_en", {31'd0, bus.wr_en_o}, 32'd1);
    chk("full_addr",  {26'd0, bus.wr_addr_o}, 32'd63);
    chk("full_done",  {31'd0, bus.done_o}, 32'd1);
    chk("full_busy0", {31'd0, bus.busy_o}, 32'd0);
    chk("full_count", {25'd0, bus.word_count_o}, 32'd64);
    send(8'hFE, 1'b0);
    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    chk("full_nwrites", log_addr.size() - base, 32'd64);
    chk("full_done_sticky", {31'd0, bus.done_o}, 32'd1);
    chk("full_count_hold", {25'd0, bus.word_count_o}, 32'd64);
    errs = 0;
    for (int i = 0; i < 64 && base + i < log_addr.size(); i++) begin
      if (log_addr[base+i] !== 6'(i) || log_data[base+i] !== 32'(i)) errs++;
    end
    chk("full_stream", errs, 32'd0);

    // Reset in the middle of a word.
    do_reset();
    base = log_addr.size();
    send(8'hFE, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    do_reset();
    send(8'hFE, 1'b0);
    send_word(32'h0102_0304);
    chk("midrst_wr_en", {31'd0, bus.wr_en_o}, 32'd1);
    chk("midrst_data",  bus.wr_data_o, 32'h0102_0304);
    chk("midrst_addr",  {26'd0, bus.wr_addr_o}, 32'd0);
    send(8'h00, 1'b0);
    chk("midrst_nwrites", log_addr.size() - base, 32'd1);

    // Reset on the edge that samples the fourth byte.
    do_reset();
    base = log_addr.size();
    send(8'hFE, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    chk("coinc_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
    chk("coinc_count", {25'd0, bus.word_count_o}, 32'd0);
    chk("coinc_busy",  {31'd0, bus.busy_o}, 32'd0);
    send(8'h55, 1'b0);
    chk("coinc_idle",  {31'd0, bus.busy_o}, 32'd0);
    send(8'h00, 1'b0);
    chk("coinc_nwrites", log_addr.size() - base, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
